ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of both requester ports and the memory word.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; memory depth SHALL be 2**ADDR_W (16 words).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-005 req_0  input  1  SHALL be the port-0 access request, held until gnt_0 is seen.
REQ-006 wr_0  input  1  SHALL select the port-0 operation: 1 = write, 0 = read; held with req_0.
REQ-007 addr_0  input  ADDR_W  SHALL be the port-0 word address; held with req_0.
REQ-008 wdata_0  input  DATA_W  SHALL be the port-0 write data; held with req_0.
REQ-009 gnt_0  output  1  SHALL be a one-cycle pulse marking the port-0 access cycle.
REQ-010 rvalid_0  output  1  SHALL be a one-cycle pulse marking valid port-0 read data.
REQ-011 rdata_0  output  DATA_W  SHALL carry the port-0 read data.
REQ-012 Port 1 SHALL have req_1, wr_1, addr_1, wdata_1, gnt_1, rvalid_1 and rdata_1, identical in direction, width and meaning to port 0.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, GNT0 and GNT1; gnt_x SHALL be 1 only in state GNTx.
REQ-014 From IDLE with one request, the FSM SHALL move to that requester's GNT state on the next edge.
REQ-015 From IDLE with both requests, the FSM SHALL move to the GNT state of the port named by the priority pointer.
REQ-016 From IDLE with no request, the FSM SHALL stay in IDLE.
REQ-017 From GNTx, req_x SHALL be ignored for the next decision, since it is consumed.
REQ-018 From GNTx, if the other port is requesting, the FSM SHALL move to the other port's GNT state; otherwise it SHALL move to IDLE.
REQ-019 Throughput SHALL be: two contending ports alternate every cycle; a lone port gets at most one access per 2 cycles.
REQ-020 After any grant to port x, the priority pointer SHALL point to the other port.
REQ-021 A write SHALL commit mem[addr_x] <= wdata_x at the edge that ends the GNTx cycle.
REQ-022 A read SHALL capture mem[addr_x] into rdata_x at the edge that ends the GNTx cycle, and rvalid_x SHALL be 1 in the following cycle.
REQ-023 rdata_x SHALL hold its value until the next read on the same port.
REQ-024 Read latency SHALL be 1 cycle from request sample to gnt, and 2 cycles from request sample to rvalid.
REQ-025 Read-after-write to the same address SHALL return the new data, including when the write and the read are in back-to-back GNT cycles.
REQ-026 A req_x that drops before gnt_x SHALL cancel the request with no access.
REQ-027 The access SHALL be performed using the address, data and operation sampled during GNTx, regardless of any req_x change in that cycle.
REQ-028 Both ports SHALL NOT be granted in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, pointer=port 0, gnt_0=gnt_1=0, rvalid_0=rvalid_1=0 and rdata_0=rdata_1=0.
REQ-030 If rst is asserted during GNTx, the access SHALL be abandoned: no write commits and no rvalid is produced.
REQ-031 Memory contents SHALL NOT be reset; a read before the first write returns undefined data.

Structure
REQ-032 Shared package ram_arb_pkg SHALL hold DATA_W/ADDR_W defaults, the DEPTH constant and the state enum (IDLE, GNT0, GNT1).
REQ-033 The storage SHALL be one sub-module, sp_ram: single port, synchronous write, registered read, DEPTH x DATA_W.
REQ-034 sp_ram SHALL be driven only by the arbiter's muxed port.

Verification
REQ-035 After reset, req_0 write addr 3 data 0xA5 -> gnt_0 in the cycle after request; then a port-1 read of addr 3 -> rdata_1=0xA5 with rvalid_1 two cycles after req_1.
REQ-036 req_0 and req_1 asserted together from reset, both held -> grants in order 0,1,0,1 on consecutive cycles; never simultaneous.
REQ-037 req_0 held alone for 6 cycles -> gnt_0 pulses on alternate cycles (3 pulses); gnt_1 stays 0.
REQ-038 Port 0 writes addr 7 = 0x3C in GNT0; port 1 reads addr 7 in the immediately following GNT1 -> rdata_1=0x3C.
REQ-039 rst pulsed during a GNT1 write of addr 2 = 0xFF, where addr 2 previously held 0x11 -> addr 2 reads back 0x11; all outputs are 0 while rst is high.
REQ-040 req_1 raised for 1 cycle and dropped while GNT0 is active -> no gnt_1 and no memory change.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the width defaults, memory depth and FSM states.
package ram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Two requester ports sharing one RAM.
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_0;
  logic              wr_0;
  logic [ADDR_W-1:0] addr_0;
  logic [DATA_W-1:0] wdata_0;
  logic              gnt_0;
  logic              rvalid_0;
  logic [DATA_W-1:0] rdata_0;

  logic              req_1;
  logic              wr_1;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_1;
  logic              gnt_1;
  logic              rvalid_1;
  logic [DATA_W-1:0] rdata_1;

  modport master (
    output req_0, wr_0, addr_0, wdata_0,
    input  gnt_0, rvalid_0, rdata_0,
    output req_1, wr_1, addr_1, wdata_1,
    input  gnt_1, rvalid_1, rdata_1
  );

  modport slave (
    input  req_0, wr_0, addr_0, wdata_0,
    output gnt_0, rvalid_0, rdata_0,
    input  req_1, wr_1, addr_1, wdata_1,
    output gnt_1, rvalid_1, rdata_1
  );

endinterface

// File: rtl/ram_port_arbiter_sp_ram.sv
// Single-port RAM: synchronous write, registered read.
// Contents are intentionally not reset.
module sp_ram
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write or read the addressed word when enabled
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter giving two ports access to one RAM.
// One GNT cycle per access; read data returns one cycle later.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               clk,
  input logic               rst,
  ram_port_arbiter_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic              ptr;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  logic              rv_0;
  logic              rv_1;
  logic [DATA_W-1:0] hold_0;
  logic [DATA_W-1:0] hold_1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: the granted port's own request is consumed
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: begin
        if (bus.req_0 && bus.req_1)
          state_nx = ptr ? GNT1 : GNT0;
        else if (bus.req_0)
          state_nx = GNT0;
        else if (bus.req_1)
          state_nx = GNT1;
        else
          state_nx = IDLE;
      end
      GNT0:    state_nx = bus.req_1 ? GNT1 : IDLE;
      GNT1:    state_nx = bus.req_0 ? GNT0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Priority pointer flips to the port not just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else begin
      if (state == GNT0) ptr <= 1'b1;
      if (state == GNT1) ptr <= 1'b0;
    end
  end

  // Mux the granted port onto the RAM
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (state)
      GNT0: begin
        ram_en    = 1'b1;
        ram_we    = bus.wr_0;
        ram_addr  = bus.addr_0;
        ram_wdata = bus.wdata_0;
      end
      GNT1: begin
        ram_en    = 1'b1;
        ram_we    = bus.wr_1;
        ram_addr  = bus.addr_1;
        ram_wdata = bus.wdata_1;
      end
      default: ram_en = 1'b0;
    endcase
  end

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Read-valid pulse follows a read grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_0 <= 1'b0;
      rv_1 <= 1'b0;
    end else begin
      rv_0 <= (state == GNT0) && !bus.wr_0;
      rv_1 <= (state == GNT1) && !bus.wr_1;
    end
  end

  // Per-port copy keeps rdata stable until that port reads again
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_0 <= '0;
      hold_1 <= '0;
    end else begin
      if (rv_0) hold_0 <= ram_q;
      if (rv_1) hold_1 <= ram_q;
    end
  end

  assign bus.gnt_0    = (state == GNT0);
  assign bus.gnt_1    = (state == GNT1);
  assign bus.rvalid_0 = rv_0;
  assign bus.rvalid_1 = rv_1;
  assign bus.rdata_0  = rv_0 ? ram_q : hold_0;
  assign bus.rdata_1  = rv_1 ? ram_q : hold_1;

endmodule
